mmio_gpio: RTL and testbench
============================

Name: mmio_gpio

Overview:
Parametrised memory-mapped GPIO peripheral, the successor to the fixed LED/switch I/O in MiniLab0. It sits on the processor data-memory bus at BASE_ADDR and provides:
- a read/write LED output register;
- a synchronised, debounced switch input register;
- per-bit switch edge capture with a maskable, level interrupt to the core.

Parameters:
LED_W, 10, LED output width (1..16)
SW_W, 10, switch input width (1..16)
DATA_W, 16, bus data width (>= max(LED_W, SW_W))
ADDR_W, 16, bus address width
BASE_ADDR, 16'hC000, base address; low 2 bits must be 0
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a switch change; 0 = bypass debounce

Ports:
CLOCK_50  input  1  system clock, all logic on posedge
RST_n  input  1  reset, synchronous, active-low
addr  input  ADDR_W  bus word address
wdata  input  DATA_W  bus write data
we  input  1  write strobe, one cycle per access
re  input  1  read strobe, one cycle per access
rdata  output  DATA_W  registered read data
SW_in  input  SW_W  raw asynchronous switches
LEDR_out  output  LED_W  LED drive
irq  output  1  interrupt, active-high level

Behaviour:
- Reset: synchronous, active-low (RST_n sampled on CLOCK_50 rising edge). On reset, every register clears: LEDR_out=0, rdata=0, irq=0, sync flops=0, debounced value=0, debounce counters=0, EDGE=0, IRQ_EN=0.
- Reset mid-operation: an access in the reset cycle is dropped.
- Decode: sel = (addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]); off = addr[1:0].
- Register map (unused upper bits read 0, writes ignored):
  - off 0 LED: R/W; LEDR_out = reg.
  - off 1 SW: RO, debounced value; writes ignored.
  - off 2 EDGE: per-bit rising-edge flags; write-1-to-clear.
  - off 3 IRQ_EN: R/W, SW_W bits.
- Write: sel && we at edge N updates the register at edge N. For LED, LEDR_out shows the new value in cycle N+1.
- Read: sel && re at edge N; rdata carries the register value (pre-write if we is also set) from edge N until the next edge.
- rdata = 0 in every cycle with no selected read, so slaves can be OR-combined.
- we and re both high: read returns the old value, write applies.
- Input path: 2-flop synchroniser per bit, then debounce.
- Debounce, DEBOUNCE_CYCLES > 0:
  - Per bit, a counter increments while the synced bit != debounced bit; it resets to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES - 1 and the bit still differs, the debounced bit takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is filtered.
  - Counter width: $clog2(DEBOUNCE_CYCLES+1).
- Debounce, DEBOUNCE_CYCLES = 0: debounced = synced.
- Latency raw->SW register: 2 + DEBOUNCE_CYCLES cycles (2 when bypassed).
- Edge capture: a 0->1 transition of debounced bit i sets EDGE[i].
  - Same cycle as a W1C of bit i: set wins, bit stays 1.
  - A falling edge does not clear EDGE.
- irq: registered, irq = |(EDGE & IRQ_EN) evaluated on the previous cycle's registers. It asserts 1 cycle after EDGE/IRQ_EN become true and deasserts 1 cycle after clear.
- Unselected addresses: no state change, rdata = 0.

Test Plan:
- Reset/LED: hold RST_n=0 with we=1, addr=C000, wdata=3FF -> LEDR_out=0. Release, write 0x001 to C000 -> LEDR_out=001 next cycle. Read C000 -> rdata=0001.
- Switch latency/debounce (DEBOUNCE_CYCLES=4): SW_in 000->001 held -> read C001 returns 0001 no earlier than 6 cycles after the change. A 3-cycle pulse of SW_in=002 -> C001 never reads 0002.
- Bypass build (DEBOUNCE_CYCLES=0, LED_W=4, SW_W=4, DATA_W=8): SW_in=3 -> C001 reads 03 after 2 cycles. Write 0xFF to C000 -> LEDR_out=F, read 0F.
- Edge/irq: IRQ_EN=0x002 via C003; raise SW bit1 -> EDGE reads 0x002 and irq=1. Write 0x002 to C002 -> EDGE=0, irq=0 one cycle later. Raise bit0 with mask 0x002 -> EDGE=0x001, irq stays 0.
- Set-vs-clear race: time a W1C of bit0 to the exact cycle bit0 debounces high -> EDGE[0]=1 afterward.
- Decode/bus: write to C004 and BFFF -> no register changes, rdata=0 on reads. Write to C001 -> SW unchanged. Idle cycles -> rdata=0.

Source files
------------

// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO slave with an LED register, a synchronised and
// debounced switch register, per-bit rising-edge capture and a masked level irq.
// Map (word offsets from BASE_ADDR): 0 LED, 1 SW (RO), 2 EDGE (W1C), 3 IRQ_EN.
module mmio_gpio #(
    parameter int                LED_W           = 10,
    parameter int                SW_W            = 10,
    parameter int                DATA_W          = 16,
    parameter int                ADDR_W          = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = 16'hC000,
    parameter int                DEBOUNCE_CYCLES = 4
) (
    input  logic              CLOCK_50,
    input  logic              RST_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] rdata,
    input  logic [SW_W-1:0]   SW_in,
    output logic [LED_W-1:0]  LEDR_out,
    output logic              irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic        sel, wr, rd;
    logic [1:0]  off;

    assign sel = (addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
    assign off = addr[1:0];
    assign wr  = sel & we;
    assign rd  = sel & re;

    // Upper write-data bits beyond the register widths are ignored.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    logic [SW_W-1:0] sync1_q, sync2_q;
    logic [SW_W-1:0] deb_cur;   // debounced value visible this cycle
    logic [SW_W-1:0] deb_nxt;   // debounced value after the coming edge

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge CLOCK_50) begin
        if (!RST_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= SW_in;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: the synchronised value is the switch value.
            assign deb_cur = sync2_q;
            assign deb_nxt = sync1_q;
        end else begin : g_deb
            logic [SW_W-1:0]         deb_q, deb_d;
            logic [SW_W-1:0][CW-1:0] cnt_q, cnt_d;

            // Per-bit stability counter; accept the new level once it has differed long enough
            always_comb begin
                deb_d = deb_q;
                cnt_d = cnt_q;
                for (int i = 0; i < SW_W; i++) begin
                    if (sync2_q[i] == deb_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        deb_d[i] = sync2_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            end

            // Debounce state registers
            always_ff @(posedge CLOCK_50) begin
                if (!RST_n) begin
                    deb_q <= '0;
                    cnt_q <= '0;
                end else begin
                    deb_q <= deb_d;
                    cnt_q <= cnt_d;
                end
            end

            assign deb_cur = deb_q;
            assign deb_nxt = deb_d;
        end
    endgenerate

    logic [LED_W-1:0]  led_q, led_d;
    logic [SW_W-1:0]   edge_q, edge_d;
    logic [SW_W-1:0]   irqen_q, irqen_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              irq_q, irq_d;

    // Register-file next state: bus writes, edge capture (set beats clear), read mux
    always_comb begin
        led_d   = led_q;
        edge_d  = edge_q;
        irqen_d = irqen_q;
        rdata_d = '0;
        if (wr) begin
            case (off)
                2'd0:    led_d   = wdata[LED_W-1:0];
                2'd2:    edge_d  = edge_q & ~wdata[SW_W-1:0];
                2'd3:    irqen_d = wdata[SW_W-1:0];
                default: ;
            endcase
        end
        edge_d = edge_d | (deb_nxt & ~deb_cur);
        if (rd) begin
            case (off)
                2'd0:    rdata_d = DATA_W'(led_q);
                2'd1:    rdata_d = DATA_W'(deb_cur);
                2'd2:    rdata_d = DATA_W'(edge_q);
                default: rdata_d = DATA_W'(irqen_q);
            endcase
        end
        irq_d = |(edge_q & irqen_q);
    end

    // Bus-visible registers and registered interrupt
    always_ff @(posedge CLOCK_50) begin
        if (!RST_n) begin
            led_q   <= '0;
            edge_q  <= '0;
            irqen_q <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            led_q   <= led_d;
            edge_q  <= edge_d;
            irqen_q <= irqen_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign LEDR_out = led_q;
    assign rdata    = rdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_gpio.sv
// Scoreboard bench for mmio_gpio: a debounced build (A) and a bypass build (B).
// Reads push the expected data; per-DUT monitors pop and compare one cycle later
// and require rdata == 0 in every cycle without a read.
module tb_mmio_gpio;

    logic CLOCK_50 = 1'b0;
    logic RST_n    = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic [15:0] addr_a = '0, wdata_a = '0, rdata_a;
    logic        we_a = 1'b0, re_a = 1'b0, irq_a;
    logic [9:0]  SW_a = '0, LED_a;

    logic [15:0] addr_b = '0;
    logic [7:0]  wdata_b = '0, rdata_b;
    logic        we_b = 1'b0, re_b = 1'b0, irq_b;
    logic [3:0]  SW_b = '0, LED_b;

    mmio_gpio u_a (
        .CLOCK_50(CLOCK_50), .RST_n(RST_n), .addr(addr_a), .wdata(wdata_a),
        .we(we_a), .re(re_a), .rdata(rdata_a), .SW_in(SW_a), .LEDR_out(LED_a), .irq(irq_a)
    );

    mmio_gpio #(.LED_W(4), .SW_W(4), .DATA_W(8), .DEBOUNCE_CYCLES(0)) u_b (
        .CLOCK_50(CLOCK_50), .RST_n(RST_n), .addr(addr_b), .wdata(wdata_b),
        .we(we_b), .re(re_b), .rdata(rdata_b), .SW_in(SW_b), .LEDR_out(LED_b), .irq(irq_b)
    );

    typedef struct { int exp; int adr; } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;
    logic rfa = 1'b0, rfb = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitors: a read sampled at a posedge is checked at the following negedge
    always @(posedge CLOCK_50) begin
        rfa <= re_a;
        rfb <= re_b;
    end

    always @(negedge CLOCK_50) begin
        exp_t t;
        if (mon_en) begin
            if (rfa) begin
                if (qa.size() == 0) chk("sb_a_empty", 1, 0);
                else begin
                    t = qa.pop_front();
                    chk($sformatf("rd_a[%04h]", t.adr), int'(rdata_a), t.exp);
                end
            end else chk("idle_rdata_a", int'(rdata_a), 0);
            if (rfb) begin
                if (qb.size() == 0) chk("sb_b_empty", 1, 0);
                else begin
                    t = qb.pop_front();
                    chk($sformatf("rd_b[%04h]", t.adr), int'(rdata_b), t.exp);
                end
            end else chk("idle_rdata_b", int'(rdata_b), 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic wr_a(input logic [15:0] a, input logic [15:0] d);
        addr_a = a; wdata_a = d; we_a = 1'b1;
        @(negedge CLOCK_50);
        we_a = 1'b0;
    endtask

    task automatic rd_a(input logic [15:0] a, input int e);
        exp_t t;
        t.exp = e; t.adr = int'(a);
        addr_a = a; re_a = 1'b1; qa.push_back(t);
        @(negedge CLOCK_50);
        re_a = 1'b0;
    endtask

    task automatic rw_a(input logic [15:0] a, input logic [15:0] d, input int e);
        exp_t t;
        t.exp = e; t.adr = int'(a);
        addr_a = a; wdata_a = d; we_a = 1'b1; re_a = 1'b1; qa.push_back(t);
        @(negedge CLOCK_50);
        we_a = 1'b0; re_a = 1'b0;
    endtask

    task automatic wr_b(input logic [15:0] a, input logic [7:0] d);
        addr_b = a; wdata_b = d; we_b = 1'b1;
        @(negedge CLOCK_50);
        we_b = 1'b0;
    endtask

    task automatic rd_b(input logic [15:0] a, input int e);
        exp_t t;
        t.exp = e; t.adr = int'(a);
        addr_b = a; re_b = 1'b1; qb.push_back(t);
        @(negedge CLOCK_50);
        re_b = 1'b0;
    endtask

    initial begin
        // Reset with a write held on the bus: it must be dropped
        addr_a = 16'hC000; wdata_a = 16'h03FF; we_a = 1'b1;
        addr_b = 16'hC000; wdata_b = 8'hFF;    we_b = 1'b1;
        @(negedge CLOCK_50);
        mon_en = 1'b1;
        idle(2);
        chk("reset_led_a", int'(LED_a), 0);
        chk("reset_irq_a", int'(irq_a), 0);
        chk("reset_led_b", int'(LED_b), 0);
        RST_n = 1'b1; we_a = 1'b0; we_b = 1'b0;
        idle(1);

        // LED write/read, then simultaneous read+write returns old value
        wr_a(16'hC000, 16'h0001);
        chk("led_after_wr", int'(LED_a), 'h001);
        rd_a(16'hC000, 'h0001);
        rw_a(16'hC000, 16'h0155, 'h0001);
        chk("led_after_rw", int'(LED_a), 'h155);
        rd_a(16'hC000, 'h0155);

        // Switch latency: change before E0, first read to see it is sampled at E6
        SW_a = 10'h001;
        for (int i = 0; i < 8; i++) rd_a(16'hC001, (i >= 6) ? 'h0001 : 'h0000);

        // Three-cycle glitch on bit1 is filtered
        SW_a = 10'h003;
        for (int i = 0; i < 3; i++) rd_a(16'hC001, 'h0001);
        SW_a = 10'h001;
        for (int i = 0; i < 8; i++) rd_a(16'hC001, 'h0001);
        rd_a(16'hC002, 'h0001);

        // Edge capture and masked interrupt
        wr_a(16'hC003, 16'h0002);
        rd_a(16'hC003, 'h0002);
        wr_a(16'hC002, 16'h03FF);
        rd_a(16'hC002, 'h0000);
        chk("irq_idle", int'(irq_a), 0);
        SW_a = 10'h003;
        idle(8);
        rd_a(16'hC002, 'h0002);
        chk("irq_set", int'(irq_a), 1);
        wr_a(16'hC002, 16'h0002);
        chk("irq_lag", int'(irq_a), 1);
        idle(1);
        chk("irq_clr", int'(irq_a), 0);
        rd_a(16'hC002, 'h0000);
        SW_a = 10'h002;
        idle(8);
        rd_a(16'hC002, 'h0000);
        SW_a = 10'h003;
        idle(8);
        rd_a(16'hC002, 'h0001);
        chk("irq_masked", int'(irq_a), 0);

        // Set-vs-clear race on bit0: W1C sampled on the edge bit0 debounces high
        SW_a = 10'h002;
        idle(8);
        wr_a(16'hC002, 16'h03FF);
        rd_a(16'hC002, 'h0000);
        SW_a = 10'h003;
        idle(5);
        wr_a(16'hC002, 16'h0001);
        rd_a(16'hC002, 'h0001);
        wr_a(16'hC002, 16'h0001);
        rd_a(16'hC002, 'h0000);

        // Decode: neighbours of the window, and writes to the read-only SW register
        wr_a(16'hC004, 16'h03FF);
        wr_a(16'hBFFF, 16'h03FF);
        chk("led_decode", int'(LED_a), 'h155);
        rd_a(16'hC004, 'h0000);
        rd_a(16'hBFFF, 'h0000);
        wr_a(16'hC001, 16'h0000);
        rd_a(16'hC001, 'h0003);
        rd_a(16'hC003, 'h0002);
        rd_a(16'hC000, 'h0155);
        idle(2);

        // Bypass build: two-cycle latency, LED truncated to 4 bits
        SW_b = 4'h3;
        for (int i = 0; i < 4; i++) rd_b(16'hC001, (i >= 2) ? 'h03 : 'h00);
        wr_b(16'hC000, 8'hFF);
        chk("led_b", int'(LED_b), 'hF);
        rd_b(16'hC000, 'h0F);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
